mmu_utlb_xlate: RTL and testbench
=================================

Name: mmu_utlb_xlate

Overview:
- Pipelined virtual-to-physical translation front end for the fetch/LSU ports of the MIPS32 core.
- Classifies each address by segment and privilege, and bypasses kseg0/kseg1 (and kuseg while ERL=1).
- Translates mapped segments through a small fully-associative micro-TLB and refills that micro-TLB from the shared main TLB over a request/response handshake.
- Raises address-error, TLB-refill, TLB-invalid and TLB-modified exception codes for the requester.

Parameters:
- ENTRIES, 4: micro-TLB entry count; power of 2, at least 2.
- ASID_W, 8: ASID width.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- cp0_status_i  in  32  CP0 Status; EXL=bit1, ERL=bit2, KSU=bits[4:3]
- cp0_config_uncache_i  in  1  1: kseg0 uncached
- cp0_asid_i  in  ASID_W  current EntryHi ASID
- flush_i  in  1  invalidate all micro-TLB entries (TLBWI/TLBWR/ASID write)
- req_valid_i  in  1  translation request
- req_ready_o  out  1  block can accept a request
- req_vaddr_i  in  32  virtual address
- req_store_i  in  1  1: store access, 0: load/fetch
- resp_valid_o  out  1  one-cycle response pulse
- resp_paddr_o  out  32  physical address
- resp_cached_o  out  1  access is cacheable
- resp_exc_o  out  3  0 none, 1 AdEL, 2 AdES, 3 TLBL-refill, 4 TLBS-refill, 5 TLBL-invalid, 6 TLBS-invalid, 7 Mod
- tlb_req_valid_o  out  1  main-TLB lookup request
- tlb_req_ready_i  in  1  main TLB accepts the lookup
- tlb_req_vpn_o  out  20  vaddr[31:12] of the missing page
- tlb_resp_valid_i  in  1  main-TLB result valid (one cycle)
- tlb_resp_found_i  in  1  matching entry exists
- tlb_resp_pfn_i  in  20  physical frame number
- tlb_resp_v_i, tlb_resp_d_i, tlb_resp_g_i  in  1 each  valid, dirty and global bits
- tlb_resp_c_i  in  3  cache attribute; cached = (C != 3'b010)

Behaviour:
- Reset (async, resetn=0): state IDLE; all entry valid bits 0; round-robin pointer 0. Outputs: req_ready_o=1, resp_valid_o=0, resp_paddr_o=0, resp_cached_o=0, resp_exc_o=0, tlb_req_valid_o=0, tlb_req_vpn_o=0.
- Reset mid-refill: the outstanding refill is abandoned and any later tlb_resp_valid_i is ignored until the next tlb request.
- Privilege modes:
  - user = !EXL && KSU==2'b10; kernel = !user.
  - Segments from vaddr[31:29]: kuseg=0xx, kseg0=100, kseg1=101, ksseg=110, kseg3=111.
- Request capture: in IDLE, req_valid_i && req_ready_o accepts the request. Status, config, ASID, vaddr and store are sampled on that edge.
- Address error: user mode && vaddr[31]=1. The response arrives the next cycle with exc=AdEL/AdES (by store) and paddr=vaddr.
- Unmapped: kernel mode and (kseg0, kseg1, or kuseg with ERL=1). The response arrives the next cycle with:
  - paddr={3'b000,vaddr[28:0]} for kseg0/kseg1, and vaddr unchanged for kuseg with ERL=1;
  - cached = kseg0 && !cp0_config_uncache_i.
- Mapped lookup: hit when an entry is valid, its VPN equals vaddr[31:12], and (G=1 or ASID equal).
  - A hit responds the next cycle with paddr={pfn,vaddr[11:0]} and the entry's cached bit.
  - Store to a hit entry with D=0 gives exc=Mod.
  - Multiple hits cannot occur; a fill is never written while the VPN/ASID is already present.
- FSM: IDLE -> REFILL_REQ on a mapped miss; req_ready_o=0 outside IDLE.
  - REFILL_REQ: tlb_req_valid_o=1 and tlb_req_vpn_o stable until tlb_req_ready_i, then go to REFILL_WAIT.
  - REFILL_WAIT: hold until tlb_resp_valid_i, then RESP.
  - RESP: resp_valid_o=1 for one cycle, then return to IDLE.
- Refill outcome:
  - !found gives exc=TLBL/TLBS-refill.
  - found && !v gives exc=TLBL/TLBS-invalid, and nothing is written.
  - found && v writes the entry at the pointer (VPN, captured ASID, pfn, d, g, cached), the pointer increments modulo ENTRIES, and the response is as for a hit, including the Mod check.
- Minimum latencies:
  - hit/bypass/error: resp_valid_o 1 cycle after acceptance;
  - miss: acceptance, then at least 1 REFILL_REQ cycle, then the response cycle, then the RESP cycle.
- Flush:
  - flush_i clears all valid bits on the next edge.
  - flush_i in the same cycle as a fill: flush wins, no entry is written, and the response is still delivered.
  - flush_i in the same cycle as an IDLE acceptance: the lookup uses pre-flush contents.
- Exception responses are never written into the micro-TLB.
- resp_* outputs hold their value when resp_valid_o=0.

Test Plan:
- Kernel (status=0), vaddr 0x8000_1234, uncache=0 -> next cycle resp_valid=1, paddr 0x0000_1234, cached=1, exc=0; the same access at 0xA000_1234 gives cached=0.
- User (KSU=10, EXL=0), load at 0x8000_0000 -> exc=1, no tlb_req; a store gives exc=2.
- User load at 0x0040_0010 on a miss -> tlb_req_vpn_o=0x00400. Hold tlb_req_ready_i=0 for 3 cycles, then respond found=1, v=1, d=1, pfn=0x12345, C=3 -> paddr 0x1234_5010, cached=1. Repeating the access hits with 1-cycle latency and no tlb_req.
- Store to a page filled with d=0 -> exc=7. Lookups with found=0 and with found=1/v=0 -> exc=4 and exc=6 respectively, and a re-access misses again.
- Fill ENTRIES+1 distinct pages -> page 0 is evicted (round-robin) and misses again. Assert flush_i on the same edge as a fill -> response delivered but the next access misses. Change ASID with g=0 -> miss; with g=1 -> hit.
- Assert resetn=0 during REFILL_WAIT -> all outputs return to reset values asynchronously, and the previously filled page misses after reset.

Source files
------------

// File: rtl/mmu_utlb_xlate.sv
// mmu_utlb_xlate: segment/privilege classifier with a round-robin micro-TLB refilled from the main TLB
module mmu_utlb_xlate #(
  parameter int ENTRIES = 4,
  parameter int ASID_W  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       cp0_status_i,
  input  logic              cp0_config_uncache_i,
  input  logic [ASID_W-1:0] cp0_asid_i,
  input  logic              flush_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_vaddr_i,
  input  logic              req_store_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_paddr_o,
  output logic              resp_cached_o,
  output logic [2:0]        resp_exc_o,
  output logic              tlb_req_valid_o,
  input  logic              tlb_req_ready_i,
  output logic [19:0]       tlb_req_vpn_o,
  input  logic              tlb_resp_valid_i,
  input  logic              tlb_resp_found_i,
  input  logic [19:0]       tlb_resp_pfn_i,
  input  logic              tlb_resp_v_i,
  input  logic              tlb_resp_d_i,
  input  logic              tlb_resp_g_i,
  input  logic [2:0]        tlb_resp_c_i
);
  localparam int PW = $clog2(ENTRIES);
  typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_WAIT, RESP} state_t;
  state_t state, state_nxt;
  logic [ENTRIES-1:0] e_v, e_d, e_g, e_c;
  logic [19:0] e_vpn [ENTRIES];
  logic [19:0] e_pfn [ENTRIES];
  logic [ASID_W-1:0] e_asid [ENTRIES];
  logic [PW-1:0] ptr;
  logic [31:0] vaddr_q;
  logic store_q;
  logic [ASID_W-1:0] asid_q;
  logic user, adr_err, unmapped, hit, hit_d, hit_c, accept, miss, fill;
  logic [19:0] hit_pfn;
  logic unused_ok;
  assign unused_ok = ^{cp0_status_i[31:5], cp0_status_i[0]};
  assign user = !cp0_status_i[1] && cp0_status_i[4:3] == 2'b10;
  assign adr_err = user && req_vaddr_i[31];
  assign unmapped = !user && (req_vaddr_i[31:30] == 2'b10 || (!req_vaddr_i[31] && cp0_status_i[2]));
  assign accept = req_valid_i && state == IDLE;
  assign miss = !adr_err && !unmapped && !hit;
  assign fill = state == REFILL_WAIT && tlb_resp_valid_i && tlb_resp_found_i && tlb_resp_v_i;
  assign req_ready_o = state == IDLE;
  assign tlb_req_valid_o = state == REFILL_REQ;
  assign tlb_req_vpn_o = vaddr_q[31:12];
  always_comb begin
    hit = 1'b0;
    hit_pfn = '0;
    hit_d = 1'b0;
    hit_c = 1'b0;
    for (int i = 0; i < ENTRIES; i++)
      if (e_v[i] && e_vpn[i] == req_vaddr_i[31:12] && (e_g[i] || e_asid[i] == cp0_asid_i)) begin
        hit = 1'b1;
        hit_pfn = e_pfn[i];
        hit_d = e_d[i];
        hit_c = e_c[i];
      end
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        state_nxt = (accept && miss) ? REFILL_REQ : IDLE;
      REFILL_REQ:  state_nxt = tlb_req_ready_i ? REFILL_WAIT : REFILL_REQ;
      REFILL_WAIT: state_nxt = tlb_resp_valid_i ? RESP : REFILL_WAIT;
      default:     state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      vaddr_q <= '0;
      store_q <= 1'b0;
      asid_q <= '0;
      resp_valid_o <= 1'b0;
      resp_paddr_o <= '0;
      resp_cached_o <= 1'b0;
      resp_exc_o <= 3'd0;
    end else begin
      state <= state_nxt;
      resp_valid_o <= 1'b0;
      if (accept) begin
        vaddr_q <= req_vaddr_i;
        store_q <= req_store_i;
        asid_q <= cp0_asid_i;
        if (adr_err) begin
          resp_valid_o <= 1'b1;
          resp_paddr_o <= req_vaddr_i;
          resp_cached_o <= 1'b0;
          resp_exc_o <= req_store_i ? 3'd2 : 3'd1;
        end else if (unmapped) begin
          resp_valid_o <= 1'b1;
          resp_paddr_o <= req_vaddr_i[31] ? {3'b000, req_vaddr_i[28:0]} : req_vaddr_i;
          resp_cached_o <= req_vaddr_i[31:29] == 3'b100 && !cp0_config_uncache_i;
          resp_exc_o <= 3'd0;
        end else if (hit) begin
          resp_valid_o <= 1'b1;
          resp_paddr_o <= {hit_pfn, req_vaddr_i[11:0]};
          resp_cached_o <= hit_c;
          resp_exc_o <= (req_store_i && !hit_d) ? 3'd7 : 3'd0;
        end
      end else if (state == REFILL_WAIT && tlb_resp_valid_i) begin
        resp_valid_o <= 1'b1;
        resp_paddr_o <= fill ? {tlb_resp_pfn_i, vaddr_q[11:0]} : vaddr_q;
        resp_cached_o <= fill && tlb_resp_c_i != 3'b010;
        resp_exc_o <= !tlb_resp_found_i ? (store_q ? 3'd4 : 3'd3) :
                      !tlb_resp_v_i ? (store_q ? 3'd6 : 3'd5) :
                      (store_q && !tlb_resp_d_i) ? 3'd7 : 3'd0;
      end
    end
  // a flush in the fill cycle wins: nothing written, pointer unchanged
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      e_v <= '0;
      ptr <= '0;
    end else if (flush_i) begin
      e_v <= '0;
    end else if (fill) begin
      e_v[ptr] <= 1'b1;
      ptr <= ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (fill && !flush_i) begin
      e_vpn[ptr] <= vaddr_q[31:12];
      e_asid[ptr] <= asid_q;
      e_pfn[ptr] <= tlb_resp_pfn_i;
      e_d[ptr] <= tlb_resp_d_i;
      e_g[ptr] <= tlb_resp_g_i;
      e_c[ptr] <= tlb_resp_c_i != 3'b010;
    end
endmodule

// File: tb/tb_mmu_utlb_xlate.sv
// tb_mmu_utlb_xlate: randomized and directed checks against a page-table/micro-TLB reference model
module tb_mmu_utlb_xlate;
  localparam int ENT = 4;
  logic clk = 1'b0, resetn = 1'b0;
  logic [31:0] cp0_status_i = '0;
  logic cp0_config_uncache_i = 1'b0;
  logic [7:0] cp0_asid_i = '0;
  logic flush_i = 1'b0, req_valid_i = 1'b0, req_store_i = 1'b0;
  logic [31:0] req_vaddr_i = '0;
  logic req_ready_o, resp_valid_o, resp_cached_o, tlb_req_valid_o;
  logic [31:0] resp_paddr_o;
  logic [2:0] resp_exc_o;
  logic [19:0] tlb_req_vpn_o;
  logic tlb_req_ready_i = 1'b0, tlb_resp_valid_i = 1'b0, tlb_resp_found_i = 1'b0;
  logic [19:0] tlb_resp_pfn_i = '0;
  logic tlb_resp_v_i = 1'b0, tlb_resp_d_i = 1'b0, tlb_resp_g_i = 1'b0;
  logic [2:0] tlb_resp_c_i = '0;
  always #5 clk = ~clk;
  mmu_utlb_xlate #(.ENTRIES(ENT), .ASID_W(8)) dut (
    .clk(clk), .resetn(resetn), .cp0_status_i(cp0_status_i), .cp0_config_uncache_i(cp0_config_uncache_i),
    .cp0_asid_i(cp0_asid_i), .flush_i(flush_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_vaddr_i(req_vaddr_i), .req_store_i(req_store_i), .resp_valid_o(resp_valid_o),
    .resp_paddr_o(resp_paddr_o), .resp_cached_o(resp_cached_o), .resp_exc_o(resp_exc_o),
    .tlb_req_valid_o(tlb_req_valid_o), .tlb_req_ready_i(tlb_req_ready_i), .tlb_req_vpn_o(tlb_req_vpn_o),
    .tlb_resp_valid_i(tlb_resp_valid_i), .tlb_resp_found_i(tlb_resp_found_i), .tlb_resp_pfn_i(tlb_resp_pfn_i),
    .tlb_resp_v_i(tlb_resp_v_i), .tlb_resp_d_i(tlb_resp_d_i), .tlb_resp_g_i(tlb_resp_g_i), .tlb_resp_c_i(tlb_resp_c_i)
  );
  int checks = 0, errors = 0;
  typedef struct packed {logic found, v, d, g; logic [19:0] pfn; logic [2:0] c;} pte_t;
  typedef struct packed {logic val; logic [19:0] vpn; logic [7:0] asid; logic [19:0] pfn; logic d, g, cached;} uent_t;
  pte_t mt [logic [19:0]];
  uent_t um [ENT];
  int uptr;
  logic [37:0] obs, exp;
  int lat;
  logic [19:0] vpn_seen;
  localparam logic [67:0] RST_OUT = {1'b1, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, 20'h0, 9'h0};
  task automatic model_reset();
    foreach (um[i]) um[i] = '0;
    uptr = 0;
  endtask
  task automatic model_access(input logic [31:0] va, input logic st, input logic [31:0] status, input logic unc,
                              input logic [7:0] asid, input logic fl, output logic [31:0] pa, output logic cached,
                              output logic [2:0] exc, output logic miss);
    logic user;
    pte_t p;
    int hi;
    user = !status[1] && status[4:3] == 2'b10;
    hi = -1;
    pa = va; cached = 1'b0; exc = 3'd0; miss = 1'b0;
    if (user && va[31]) exc = st ? 3'd2 : 3'd1;
    else if (!user && va[31:30] == 2'b10) begin
      pa = va & 32'h1FFF_FFFF;
      cached = va[31:29] == 3'b100 && !unc;
    end else if (!user && !va[31] && status[2]) begin
      pa = va;
    end else begin
      foreach (um[i]) if (um[i].val && um[i].vpn == va[31:12] && (um[i].g || um[i].asid == asid)) hi = i;
      if (hi >= 0) begin
        pa = {um[hi].pfn, va[11:0]};
        cached = um[hi].cached;
        exc = (st && !um[hi].d) ? 3'd7 : 3'd0;
      end else begin
        miss = 1'b1;
        p = mt.exists(va[31:12]) ? mt[va[31:12]] : '0;
        if (!p.found) exc = st ? 3'd4 : 3'd3;
        else if (!p.v) exc = st ? 3'd6 : 3'd5;
        else begin
          pa = {p.pfn, va[11:0]};
          cached = p.c != 3'b010;
          exc = (st && !p.d) ? 3'd7 : 3'd0;
          if (!fl) begin
            um[uptr] = '{1'b1, va[31:12], asid, p.pfn, p.d, p.g, p.c != 3'b010};
            uptr = (uptr + 1) % ENT;
          end
        end
      end
    end
  endtask
  // drives one request, plays the main TLB, and packs observed/expected {got,miss,exc,paddr,cached}
  task automatic run(input logic [31:0] va, input logic st, input logic [31:0] status, input logic unc,
                     input logic [7:0] asid, input int dly, input logic fl);
    logic [31:0] epa, rpa;
    logic ec, emiss, got, rmiss, hs, sent, rc, pchk, cchk;
    logic [2:0] eexc, rexc;
    pte_t p;
    int d;
    model_access(va, st, status, unc, asid, fl, epa, ec, eexc, emiss);
    d = dly; got = 0; rmiss = 0; hs = 0; sent = 0; lat = 0; rpa = '0; rc = 0; rexc = '0;
    @(negedge clk);
    req_valid_i = 1; req_vaddr_i = va; req_store_i = st; cp0_status_i = status;
    cp0_config_uncache_i = unc; cp0_asid_i = asid;
    for (int c = 0; c < 60 && !got; c++) begin
      @(negedge clk);
      lat++;
      req_valid_i = 0; tlb_req_ready_i = 0; tlb_resp_valid_i = 0; flush_i = 0;
      if (resp_valid_o) begin
        got = 1; rpa = resp_paddr_o; rc = resp_cached_o; rexc = resp_exc_o;
      end else if (tlb_req_valid_o) begin
        rmiss = 1; vpn_seen = tlb_req_vpn_o;
        if (d > 0) d--;
        else begin tlb_req_ready_i = 1; hs = 1; end
      end else if (hs && !sent) begin
        p = mt.exists(vpn_seen) ? mt[vpn_seen] : '0;
        tlb_resp_valid_i = 1; tlb_resp_found_i = p.found; tlb_resp_pfn_i = p.pfn; tlb_resp_v_i = p.v;
        tlb_resp_d_i = p.d; tlb_resp_g_i = p.g; tlb_resp_c_i = p.c; flush_i = fl; sent = 1;
      end
    end
    pchk = eexc inside {3'd0, 3'd1, 3'd2, 3'd7};
    cchk = eexc inside {3'd0, 3'd7};
    obs = {got, rmiss, rexc, pchk ? rpa : 32'h0, cchk ? rc : 1'b0};
    exp = {1'b1, emiss, eexc, pchk ? epa : 32'h0, cchk ? ec : 1'b0};
  endtask
  task automatic do_reset();
    @(negedge clk);
    resetn = 0;
    @(negedge clk);
    resetn = 1;
    model_reset();
  endtask
  task automatic test_reset();
    #3;
    checks++;
    if ({req_ready_o, resp_valid_o, resp_paddr_o, resp_cached_o, resp_exc_o, tlb_req_valid_o, tlb_req_vpn_o, 9'h0} !== RST_OUT) begin
      errors++;
      $display("FAIL reset_outputs got ready=%b rv=%b pa=%h c=%b exc=%0d tv=%b vpn=%h", req_ready_o, resp_valid_o,
               resp_paddr_o, resp_cached_o, resp_exc_o, tlb_req_valid_o, tlb_req_vpn_o);
    end
    @(negedge clk);
    resetn = 1;
    model_reset();
  endtask
  task automatic test_unmapped();
    run(32'h8000_1234, 0, 32'h0, 0, 8'h0, 0, 0);
    checks++;
    if (obs !== exp || obs[32:1] !== 32'h0000_1234 || lat !== 1) begin errors++; $display("FAIL kseg0 obs=%h exp=%h lat=%0d", obs, exp, lat); end
    run(32'hA000_1234, 0, 32'h0, 0, 8'h0, 0, 0);
    checks++;
    if (obs !== exp || obs[0] !== 1'b0) begin errors++; $display("FAIL kseg1 obs=%h exp=%h", obs, exp); end
    run(32'h8000_5678, 1, 32'h0, 1, 8'h0, 0, 0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL kseg0_uncached obs=%h exp=%h", obs, exp); end
    run(32'h0040_0010, 0, 32'h4, 0, 8'h0, 0, 0);
    checks++;
    if (obs !== exp || lat !== 1) begin errors++; $display("FAIL kuseg_erl obs=%h exp=%h lat=%0d", obs, exp, lat); end
  endtask
  task automatic test_adr_err();
    run(32'h8000_0000, 0, 32'h10, 0, 8'h1, 0, 0);
    checks++;
    if (obs !== exp || obs[35:33] !== 3'd1) begin errors++; $display("FAIL adel obs=%h exp=%h", obs, exp); end
    run(32'h8000_0000, 1, 32'h10, 0, 8'h1, 0, 0);
    checks++;
    if (obs !== exp || obs[35:33] !== 3'd2) begin errors++; $display("FAIL ades obs=%h exp=%h", obs, exp); end
  endtask
  task automatic test_refill();
    mt[20'h00400] = '{1'b1, 1'b1, 1'b1, 1'b0, 20'h12345, 3'd3};
    run(32'h0040_0010, 0, 32'h10, 0, 8'h1, 3, 0);
    checks++;
    if (obs !== exp || vpn_seen !== 20'h00400 || lat !== 6 || obs[32:1] !== 32'h1234_5010)
      begin errors++; $display("FAIL refill obs=%h exp=%h vpn=%h lat=%0d", obs, exp, vpn_seen, lat); end
    run(32'h0040_0010, 0, 32'h10, 0, 8'h1, 0, 0);
    checks++;
    if (obs !== exp || lat !== 1 || obs[36] !== 1'b0) begin errors++; $display("FAIL refill_rehit obs=%h exp=%h lat=%0d", obs, exp, lat); end
  endtask
  task automatic test_exceptions();
    mt[20'h00500] = '{1'b1, 1'b1, 1'b0, 1'b0, 20'h0AAAA, 3'd2};
    mt[20'h00700] = '{1'b1, 1'b0, 1'b1, 1'b0, 20'h0BBBB, 3'd3};
    run(32'h0050_0004, 0, 32'h10, 0, 8'h1, 0, 0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL clean_fill obs=%h exp=%h", obs, exp); end
    run(32'h0050_0008, 1, 32'h10, 0, 8'h1, 0, 0);
    checks++;
    if (obs !== exp || obs[35:33] !== 3'd7) begin errors++; $display("FAIL mod obs=%h exp=%h", obs, exp); end
    run(32'h0060_0000, 1, 32'h10, 0, 8'h1, 1, 0);
    checks++;
    if (obs !== exp || obs[35:33] !== 3'd4) begin errors++; $display("FAIL tlbs_refill obs=%h exp=%h", obs, exp); end
    run(32'h0060_0000, 0, 32'h10, 0, 8'h1, 0, 0);
    checks++;
    if (obs !== exp || obs[36] !== 1'b1) begin errors++; $display("FAIL refill_remiss obs=%h exp=%h", obs, exp); end
    run(32'h0070_0000, 1, 32'h10, 0, 8'h1, 0, 0);
    checks++;
    if (obs !== exp || obs[35:33] !== 3'd6) begin errors++; $display("FAIL tlbs_invalid obs=%h exp=%h", obs, exp); end
    run(32'h0070_0000, 0, 32'h10, 0, 8'h1, 0, 0);
    checks++;
    if (obs !== exp || obs[36] !== 1'b1) begin errors++; $display("FAIL invalid_remiss obs=%h exp=%h", obs, exp); end
  endtask
  task automatic test_eviction();
    do_reset();
    for (int k = 0; k < ENT + 1; k++) begin
      mt[20'h01000 + 20'(k)] = '{1'b1, 1'b1, 1'b1, 1'b0, 20'h20000 + 20'(k), 3'd3};
      run({20'h01000 + 20'(k), 12'h100}, 0, 32'h0, 0, 8'h2, 0, 0);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL evict_fill%0d obs=%h exp=%h", k, obs, exp); end
    end
    run(32'h0100_0100, 0, 32'h0, 0, 8'h2, 0, 0);
    checks++;
    if (obs !== exp || obs[36] !== 1'b1) begin errors++; $display("FAIL evicted_page obs=%h exp=%h", obs, exp); end
  endtask
  task automatic test_flush();
    mt[20'h02000] = '{1'b1, 1'b1, 1'b1, 1'b0, 20'h33333, 3'd3};
    run(32'h0200_0010, 0, 32'h0, 0, 8'h2, 0, 1);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL flush_fill_resp obs=%h exp=%h", obs, exp); end
    run(32'h0200_0010, 0, 32'h0, 0, 8'h2, 0, 0);
    checks++;
    if (obs !== exp || obs[36] !== 1'b1) begin errors++; $display("FAIL flush_fill_remiss obs=%h exp=%h", obs, exp); end
    @(negedge clk);
    flush_i = 1;
    @(negedge clk);
    flush_i = 0;
    foreach (um[i]) um[i].val = 1'b0;
    run(32'h0200_0010, 0, 32'h0, 0, 8'h2, 0, 0);
    checks++;
    if (obs !== exp || obs[36] !== 1'b1) begin errors++; $display("FAIL idle_flush obs=%h exp=%h", obs, exp); end
  endtask
  task automatic test_asid();
    mt[20'h03000] = '{1'b1, 1'b1, 1'b1, 1'b0, 20'h44444, 3'd3};
    mt[20'h03001] = '{1'b1, 1'b1, 1'b1, 1'b1, 20'h55555, 3'd3};
    run(32'h0300_0000, 0, 32'h0, 0, 8'h5, 0, 0);
    run(32'h0300_0000, 0, 32'h0, 0, 8'h6, 0, 0);
    checks++;
    if (obs !== exp || obs[36] !== 1'b1) begin errors++; $display("FAIL asid_nonglobal obs=%h exp=%h", obs, exp); end
    run(32'h0300_1000, 0, 32'h0, 0, 8'h5, 0, 0);
    run(32'h0300_1000, 0, 32'h0, 0, 8'h9, 0, 0);
    checks++;
    if (obs !== exp || obs[36] !== 1'b0) begin errors++; $display("FAIL asid_global obs=%h exp=%h", obs, exp); end
  endtask
  task automatic test_random();
    logic [19:0] vpns [8];
    logic [31:0] stl [5];
    logic [31:0] va;
    int r;
    stl = '{32'h0, 32'h10, 32'h12, 32'h4, 32'h14};
    for (int k = 0; k < 8; k++) begin
      vpns[k] = (k < 6) ? 20'h00800 + 20'(k) : 20'hC0010 + 20'(k);
      mt[vpns[k]] = '{($urandom % 5) != 0, ($urandom % 4) != 0, 1'($urandom), 1'($urandom), 20'($urandom), 3'($urandom)};
    end
    for (int n = 0; n < 60; n++) begin
      r = $urandom % 10;
      va = (r < 7) ? {vpns[$urandom % 8], 12'($urandom)} : {(r == 7) ? 3'b100 : 3'b101, 29'($urandom)};
      run(va, 1'($urandom), stl[$urandom % 5], 1'($urandom), 8'(1 + $urandom % 2), $urandom % 3, 0);
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL random%0d va=%h obs=%h exp=%h", n, va, obs, exp); end
    end
  endtask
  task automatic test_reset_mid_refill();
    mt[20'h04000] = '{1'b1, 1'b1, 1'b1, 1'b0, 20'h66666, 3'd3};
    mt[20'h05000] = '{1'b1, 1'b1, 1'b1, 1'b0, 20'h77777, 3'd3};
    run(32'h0400_0020, 0, 32'h0, 0, 8'h3, 0, 0);
    @(negedge clk);
    req_valid_i = 1; req_vaddr_i = 32'h0500_0ABC; req_store_i = 0; cp0_status_i = 32'h0; cp0_asid_i = 8'h3;
    @(negedge clk);
    req_valid_i = 0;
    checks++;
    if (tlb_req_valid_o !== 1'b1 || tlb_req_vpn_o !== 20'h05000) begin errors++; $display("FAIL mid_req tv=%b vpn=%h", tlb_req_valid_o, tlb_req_vpn_o); end
    tlb_req_ready_i = 1;
    @(negedge clk);
    tlb_req_ready_i = 0;
    #2 resetn = 0;
    #1;
    checks++;
    if ({req_ready_o, resp_valid_o, resp_paddr_o, resp_cached_o, resp_exc_o, tlb_req_valid_o, tlb_req_vpn_o, 9'h0} !== RST_OUT) begin
      errors++;
      $display("FAIL async_reset got ready=%b rv=%b pa=%h c=%b exc=%0d tv=%b vpn=%h", req_ready_o, resp_valid_o,
               resp_paddr_o, resp_cached_o, resp_exc_o, tlb_req_valid_o, tlb_req_vpn_o);
    end
    @(negedge clk);
    resetn = 1;
    model_reset();
    tlb_resp_valid_i = 1; tlb_resp_found_i = 1; tlb_resp_v_i = 1; tlb_resp_pfn_i = 20'h77777;
    @(negedge clk);
    tlb_resp_valid_i = 0;
    @(negedge clk);
    checks++;
    if (resp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin errors++; $display("FAIL stale_resp rv=%b ready=%b", resp_valid_o, req_ready_o); end
    run(32'h0400_0020, 0, 32'h0, 0, 8'h3, 0, 0);
    checks++;
    if (obs !== exp || obs[36] !== 1'b1) begin errors++; $display("FAIL post_reset_miss obs=%h exp=%h", obs, exp); end
  endtask
  initial begin
    test_reset();
    test_unmapped();
    test_adr_err();
    test_refill();
    test_exceptions();
    test_eviction();
    test_flush();
    test_asid();
    test_random();
    test_reset_mid_refill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
